// File: rtl/cdc_hs_dst_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_hs_dst_if
//  Purpose  : Bundles the asynchronous request/acknowledge/data handshake and
//             the destination-side ready/valid buffer port of cdc_hs_dst.
//             Member names are relative to the receiver block.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdc_hs_dst_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    logic                       async_req_i;
    logic [DATA_W-1:0]          async_data_i;
    logic                       async_ack_o;
    logic                       valid_o;
    logic [DATA_W-1:0]          data_o;
    logic                       ready_i;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    // Environment side: source of requests and consumer of the buffer head
    modport master (
        output async_req_i,
        output async_data_i,
        output ready_i,
        input  async_ack_o,
        input  valid_o,
        input  data_o,
        input  count_o
    );

    // Receiver side: the cdc_hs_dst block
    modport slave (
        input  async_req_i,
        input  async_data_i,
        input  ready_i,
        output async_ack_o,
        output valid_o,
        output data_o,
        output count_o
    );
endinterface
`default_nettype wire

// File: rtl/cdc_hs_dst.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_hs_dst
//  Purpose  : Destination half of a request/acknowledge clock-domain crossing.
//             Synchronises the source request, captures the (unsynchronised,
//             held-stable) source data into a small FIFO and acknowledges.
//             Supports two-phase (toggle) and four-phase (level) protocols.
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_hs_dst #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2,
    parameter bit PHASE4      = 1'b0
) (
    input  wire logic   clk_i,
    input  wire logic   rst_ni,
    cdc_hs_dst_if.slave hs
);
    // A one-entry buffer still needs a one-bit pointer
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACKED = 1'b1
    } state_t;

    // Request synchroniser; only the last stage feeds logic
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;

    // Handshake control
    state_t r_state;
    state_t w_state_nxt;
    logic   r_ack;
    logic   w_ack_nxt;
    logic   w_push;

    // Receive buffer
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;
    logic              w_space;

    // Shift the asynchronous request through the synchroniser chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], hs.async_req_i};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // Space is judged on the registered occupancy, so a pop in a full cycle
    // only frees the slot for the following cycle.
    assign w_space = (r_count < c_DEPTH_CNT);
    assign w_pop   = (r_count != '0) && hs.ready_i;

    // State and acknowledge registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Handshake decode: decides capture, next acknowledge level and next state
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_push      = 1'b0;
        if (PHASE4) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_s && w_space) begin
                        w_push      = 1'b1;
                        w_ack_nxt   = 1'b1;
                        w_state_nxt = ST_ACKED;
                    end
                end
                ST_ACKED: begin
                    // Wait for the source to drop its request; never capture here
                    if (!w_req_s) begin
                        w_ack_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            // Toggle protocol: a pending word is a level mismatch of req and ack
            w_state_nxt = ST_IDLE;
            if ((r_state == ST_IDLE) && (w_req_s != r_ack) && w_space) begin
                w_push    = 1'b1;
                w_ack_nxt = ~r_ack;
            end
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= hs.async_data_i;
        end
    end

    // Buffer pointers and occupancy, wrapping modulo DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign hs.async_ack_o = r_ack;
    assign hs.valid_o     = (r_count != '0);
    assign hs.data_o      = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign hs.count_o     = r_count;

endmodule
`default_nettype wire

// File: doc/cdc_hs_dst.md
CDC_HS_DST -- requirements
Module: cdc_hs_dst

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 32: width of transferred word.
- SYNC_STAGES, 2: request synchroniser depth; legal values 2..4.
- DEPTH, 2: receive buffer entries; power of two, 1..16.
- PHASE4, 0: 0 = two-phase (toggle) handshake; 1 = four-phase (level) handshake.

REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1: destination clock.
- rst_ni, in, 1: reset; asynchronous, active-low.
- async_req_i, in, 1: request from source domain; asynchronous.
- async_data_i, in, DATA_W: data from source domain; stable from req change until ack observed.
- async_ack_o, out, 1: acknowledge to source domain; registered.
- valid_o, out, 1: buffer head valid.
- data_o, out, DATA_W: buffer head data.
- ready_i, in, 1: downstream accepts head.
- count_o, out, $clog2(DEPTH+1): buffer occupancy.

Function
REQ-003 The block SHALL synchronise async_req_i through SYNC_STAGES flops; only the last stage (req_s) is used by logic; async_data_i SHALL NOT be synchronised.
REQ-004 The FSM SHALL have states IDLE and ACKED; PHASE4=0 SHALL use IDLE only.
REQ-005 PHASE4=0: event = (req_s != async_ack_o) in IDLE; on event with count_o < DEPTH, capture async_data_i and toggle async_ack_o at the same edge.
REQ-006 PHASE4=1, IDLE: req_s=1 and count_o < DEPTH -> capture, async_ack_o<=1, go ACKED.
REQ-007 PHASE4=1, ACKED: req_s=0 -> async_ack_o<=0, go IDLE; otherwise hold; no capture in ACKED.
REQ-008 Full buffer SHALL back-pressure: event stays pending, no ack, no data loss; capture occurs on the first edge where count_o < DEPTH is true at cycle start.
REQ-009 A pop during a full cycle SHALL NOT enable a capture in that same cycle; the capture happens the next cycle.
REQ-010 Capture SHALL happen at most once per handshake.
REQ-011 Latency: req change before edge 1 -> req_s updates at edge SYNC_STAGES -> capture, ack change and valid_o=1 after edge SYNC_STAGES+1.
REQ-012 Buffer SHALL be FIFO: valid_o = (count_o != 0); data_o = oldest entry; pop when valid_o & ready_i.
REQ-013 Simultaneous push and pop with count_o in 1..DEPTH-1 SHALL leave count_o unchanged and preserve order.
REQ-014 When count_o = 0, a push SHALL NOT be visible on valid_o in the same cycle; there is no fall-through.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 data_o SHALL hold while valid_o & !ready_i.

Reset
REQ-017 On rst_ni low:
- sync chain, async_ack_o, valid_o, count_o, pointers <= 0; FSM <= IDLE.
- data_o SHALL be 0 while count_o = 0.
REQ-018 Reset mid-transfer SHALL discard buffered and pending words; the source domain SHALL be reset in the same window so req returns to 0 (two-phase: levels realign to 0).
REQ-019 Deassertion needs no synchronisation inside this block; the integrator supplies a deasserted-synchronous rst_ni.

Verification
REQ-020 PHASE4=0, SYNC_STAGES=2: req 0->1 with data 0xA5A5_0001, ready_i=1 -> after edge 3: valid_o=1, data_o=0xA5A5_0001, async_ack_o=1; next cycle count_o=0.
REQ-021 PHASE4=1: req high with 0x1234 -> ack rises; then req low -> ack falls SYNC_STAGES+1 edges later; exactly one word delivered.
REQ-022 DEPTH=2, ready_i=0, three toggles with data 1,2,3 -> count_o=2, third ack withheld. Raise ready_i -> outputs 1,2,3 in order; third ack follows the first pop by one cycle.
REQ-023 DEPTH=4, continuous requests with ready_i=1 -> no loss. Pointer wrap exercised beyond 8 words with data order preserved.
REQ-024 Assert rst_ni low while count_o=2 and ack pending -> all outputs 0 immediately (asynchronous). After release, with req at 0 -> no spurious capture.
REQ-025 Randomised source/destination clock ratios 1:3 and 3:1, 1000 words -> scoreboard match, no duplicates.
